// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator: CIC decimator that turns the modulator's 1-bit PDM stream back into signed PCM
module pdm_cic_decimator #(
    parameter int ORDER    = 3,
    parameter int DEC_LOG2 = 6,
    parameter int OUT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             pdm_i,
    input  logic             pdm_valid_i,
    output logic [OUT_W-1:0] pcm_o,
    output logic             pcm_valid_o,
    output logic             sat_o
);
    localparam int ACC_W = ORDER * DEC_LOG2 + 1;
    // one guard bit so full-scale +R**ORDER does not alias onto -R**ORDER
    localparam int IW = ACC_W + 1;
    localparam int SH = ACC_W - OUT_W;
    localparam logic signed [IW-1:0] PMAX = IW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IW-1:0] NMIN = -PMAX - IW'(1);
    logic [DEC_LOG2-1:0] cnt;
    logic signed [IW-1:0] acc [ORDER];
    logic signed [IW-1:0] acc_nx [ORDER];
    logic signed [IW-1:0] dly [ORDER];
    logic signed [IW-1:0] comb [ORDER];
    logic signed [IW-1:0] s;
    logic accept, frame;
    assign accept = enable_i & pdm_valid_i;
    assign frame  = accept & (&cnt);
    always_comb begin
        acc_nx[0] = acc[0] + {{(IW - 1){~pdm_i}}, 1'b1};
        for (int k = 1; k < ORDER; k++) acc_nx[k] = acc[k] + acc[k-1];
        comb[0] = acc_nx[ORDER-1] - dly[0];
        for (int k = 1; k < ORDER; k++) comb[k] = comb[k-1] - dly[k];
        s = comb[ORDER-1] >>> SH;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i || !enable_i) begin
            cnt         <= '0;
            pcm_o       <= '0;
            pcm_valid_o <= 1'b0;
            sat_o       <= 1'b0;
            for (int k = 0; k < ORDER; k++) begin
                acc[k] <= '0;
                dly[k] <= '0;
            end
        end else begin
            pcm_valid_o <= frame;
            sat_o       <= frame && (s > PMAX);
            if (accept) begin
                cnt <= cnt + DEC_LOG2'(1);
                for (int k = 0; k < ORDER; k++) acc[k] <= acc_nx[k];
            end
            if (frame) begin
                dly[0] <= acc_nx[ORDER-1];
                for (int k = 1; k < ORDER; k++) dly[k] <= comb[k-1];
                pcm_o <= (s > PMAX) ? OUT_W'(PMAX) : (s < NMIN) ? OUT_W'(NMIN) : s[OUT_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_pdm_cic_decimator.sv
// tb_pdm_cic_decimator: directed vectors, reset/enable corners and random traffic against a
// binomial-weight CIC reference model.
module tb_pdm_cic_decimator;
    localparam int ORDER = 3, DEC_LOG2 = 6, OUT_W = 16, R = 64;
    localparam int IW = ORDER * DEC_LOG2 + 2;
    localparam int SH = IW - 1 - OUT_W;

    logic clk = 1'b0, rst = 1'b1, en = 1'b0, pdm = 1'b0, vld = 1'b0;
    logic [OUT_W-1:0] pcm;
    logic pv, sat;

    pdm_cic_decimator #(.ORDER(ORDER), .DEC_LOG2(DEC_LOG2), .OUT_W(OUT_W)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .pdm_i(pdm), .pdm_valid_i(vld),
        .pcm_o(pcm), .pcm_valid_o(pv), .sat_o(sat)
    );

    always #5 clk = ~clk;

    int checks = 0, passed = 0;
    longint hist[$];
    longint frames[$];
    logic [OUT_W-1:0] m_pcm = '0;
    logic m_vld = 1'b0, m_sat = 1'b0;

    typedef struct {
        logic [3:0] pat;
        int plen;
        int vper;
        int exp_pcm;
        logic exp_sat;
    } vec_t;

    function automatic longint binom(longint n, int k);
        longint r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    // last integrator after sample n is a binomially weighted sum of the inputs
    function automatic longint last_int();
        longint n = longint'(hist.size()) - 1;
        longint acc = 0;
        for (longint j = 0; j <= n - ORDER + 1; j++) acc += hist[j] * binom(n - j, ORDER - 1);
        return acc;
    endfunction

    task automatic emit();
        longint c = 0, cr, sv;
        int m;
        logic signed [IW-1:0] cw;
        frames.push_back(last_int());
        m = frames.size() - 1;
        for (int k = 0; k <= ORDER; k++)
            if (m - k >= 0) c += ((k % 2) ? -1 : 1) * binom(ORDER, k) * frames[m-k];
        cw = c[IW-1:0];
        cr = longint'(cw);
        sv = cr >>> SH;
        m_sat = sv > 32767;
        m_pcm = (sv > 32767) ? 16'h7fff : (sv < -32768) ? 16'h8000 : sv[OUT_W-1:0];
        m_vld = 1'b1;
    endtask

    task automatic model_step(input logic r, input logic e, input logic p, input logic v);
        if (r || !e) begin
            hist.delete();
            frames.delete();
            m_pcm = '0;
            m_vld = 1'b0;
            m_sat = 1'b0;
        end else begin
            m_vld = 1'b0;
            m_sat = 1'b0;
            if (v) begin
                hist.push_back(p ? 1 : -1);
                if (hist.size() % R == 0) emit();
            end
        end
    endtask

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic step(input logic r, input logic e, input logic p, input logic v);
        rst = r; en = e; pdm = p; vld = v;
        @(posedge clk);
        #1;
        model_step(r, e, p, v);
        check("pcm_valid", longint'(pv), longint'(m_vld));
        check("pcm", longint'($signed(pcm)), longint'($signed(m_pcm)));
        check("sat", longint'(sat), longint'(m_sat));
    endtask

    vec_t vt[5];
    int ones_seq[6];
    logic [3:0] pt;
    logic bv, vv;
    int a, np, last, k, dens;

    initial begin
        vt[0] = '{4'b0001, 1, 1, 32767, 1'b1};
        vt[1] = '{4'b0000, 1, 1, -32768, 1'b0};
        vt[2] = '{4'b0010, 2, 1, 0, 1'b0};
        vt[3] = '{4'b1110, 4, 1, 16384, 1'b0};
        vt[4] = '{4'b1110, 4, 4, 16384, 1'b0};
        ones_seq = '{5208, 27048, 32767, 32767, 32767, 32767};

        for (int i = 0; i < 5; i++) begin
            pt = vt[i].pat;
            a = 0; np = 0; last = -1;
            step(1'b1, 1'b0, 1'b0, 1'b0);
            for (int c = 0; c < 7 * R * vt[i].vper; c++) begin
                vv = (c % vt[i].vper) == 0;
                bv = pt[vt[i].plen - 1 - (a % vt[i].plen)];
                step(1'b0, 1'b1, vv ? bv : 1'($urandom_range(0, 1)), vv);
                if (vv) a++;
                if (pv) begin
                    if (last >= 0) check("pulse_gap", c - last, R * vt[i].vper);
                    last = c;
                    if (i == 0 && np < 6) check("ones_seq", longint'($signed(pcm)), ones_seq[np]);
                    np++;
                    if (np >= 4) begin
                        check("settled_pcm", longint'($signed(pcm)), vt[i].exp_pcm);
                        check("settled_sat", longint'(sat), longint'(vt[i].exp_sat));
                    end
                end
            end
            check("pulse_count", np, 7);
        end

        // reset pulse at accepted bit 30 of the third frame
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 2 * R + 30; c++) step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("rst_pcm_zero", longint'(pcm), 0);
        check("rst_valid_zero", longint'(pv), 0);
        check("rst_sat_zero", longint'(sat), 0);
        k = 0;
        for (int c = 1; c <= 200 && k == 0; c++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1);
            if (pv) k = c;
        end
        check("rst_restart_bits", k, R);

        // enable drops exactly on a frame event
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3 * R + 63; c++) step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("dis_no_pulse", longint'(pv), 0);
        check("dis_pcm_zero", longint'(pcm), 0);
        np = 0;
        for (int c = 0; c < 6 * R; c++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1);
            if (pv) begin
                if (np < 6) check("reen_seq", longint'($signed(pcm)), ones_seq[np]);
                np++;
            end
        end
        check("reen_pulse_count", np, 6);

        // random traffic with density segments, strobe gaps, enable drops and resets
        step(1'b1, 1'b0, 1'b0, 1'b0);
        dens = 50;
        for (int c = 0; c < 6000; c++) begin
            if (c % 500 == 0) dens = $urandom_range(0, 100);
            step(1'($urandom_range(0, 1499) == 0), 1'($urandom_range(0, 399) != 0),
                 1'($urandom_range(0, 99) < dens), 1'($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
